// File: rtl/ub_ctrl_pkg.sv
// Shared types for the unified-buffer affine schedule controller.
package ub_ctrl_pkg;

  localparam int unsigned UB_CTRL_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } ub_ctrl_state_e;

  typedef logic [2:0][UB_CTRL_WIDTH-1:0] ub_ctrl_vars_t;

endpackage

// File: rtl/ub_ctrl_dim_counter.sv
// One loop dimension: counts 0..EXT-1, flags the last value so the next level can carry.
module ub_ctrl_dim_counter
  import ub_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = UB_CTRL_WIDTH,
  parameter int unsigned EXT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] val,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(EXT - 1);

  assign wrap = (val == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val <= '0;
    end else if (clr) begin
      val <= '0;
    end else if (inc) begin
      val <= wrap ? '0 : val + WIDTH'(1);
    end
  end

endmodule

// File: rtl/ub_affine_ctrl.sv
// Affine 3-level loop-nest scheduler driving one UB port's enable and ctrl_vars.
// Define UB_AFFINE_CTRL_ADDR_EN to add the registered linear `addr` output.
module ub_affine_ctrl
  import ub_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = UB_CTRL_WIDTH,
  parameter int unsigned EXT0        = 1,
  parameter int unsigned EXT1        = 62,
  parameter int unsigned EXT2        = 62,
  parameter int unsigned START_DELAY = 0,
  parameter int unsigned II          = 1,
  parameter int unsigned STRIDE0     = 0,
  parameter int unsigned STRIDE1     = 62,
  parameter int unsigned STRIDE2     = 1,
  parameter int unsigned OFFSET      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  stall,
  output logic                  en,
  output logic [2:0][WIDTH-1:0] ctrl_vars,
  output logic                  busy,
  output logic                  done
`ifdef UB_AFFINE_CTRL_ADDR_EN
  ,
  output logic [WIDTH-1:0]      addr
`endif
);

  // WAIT compares against START_DELAY-1 so that the issuing edge is E0+START_DELAY.
  localparam logic [WIDTH-1:0] DELAY_LAST = WIDTH'((START_DELAY == 0) ? 0 : START_DELAY - 1);
  localparam logic [WIDTH-1:0] II_LAST    = WIDTH'(II - 1);
  localparam logic             NO_DELAY   = (START_DELAY == 0);

  ub_ctrl_state_e   state, state_d;
  logic [WIDTH-1:0] delay_cnt, delay_cnt_d;
  logic [WIDTH-1:0] ii_cnt, ii_cnt_d;
  logic             en_d, busy_d, done_d;
  logic             issue, clr;
  logic [2:0]       inc, wrap;
  logic             last, ii_wrap;

  assign last    = &wrap;
  assign ii_wrap = (ii_cnt == II_LAST);

  // Index chain: [2] innermost, carries ripple toward [0].
  assign inc[2] = issue;
  assign inc[1] = issue & wrap[2];
  assign inc[0] = issue & wrap[2] & wrap[1];

  ub_ctrl_dim_counter #(.WIDTH(WIDTH), .EXT(EXT0)) u_dim0 (
    .clk(clk), .rst_n(rst_n), .inc(inc[0]), .clr(clr), .val(ctrl_vars[0]), .wrap(wrap[0])
  );
  ub_ctrl_dim_counter #(.WIDTH(WIDTH), .EXT(EXT1)) u_dim1 (
    .clk(clk), .rst_n(rst_n), .inc(inc[1]), .clr(clr), .val(ctrl_vars[1]), .wrap(wrap[1])
  );
  ub_ctrl_dim_counter #(.WIDTH(WIDTH), .EXT(EXT2)) u_dim2 (
    .clk(clk), .rst_n(rst_n), .inc(inc[2]), .clr(clr), .val(ctrl_vars[2]), .wrap(wrap[2])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (flush) begin
      state_d = NO_DELAY ? RUN : WAIT;
    end else if (!stall) begin
      case (state)
        WAIT:    if (delay_cnt == DELAY_LAST) state_d = RUN;
        RUN:     if (ii_wrap && last) state_d = DONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    delay_cnt_d = delay_cnt;
    ii_cnt_d    = ii_cnt;
    en_d        = 1'b0;
    busy_d      = busy;
    done_d      = done;
    issue       = 1'b0;
    clr         = 1'b0;
    if (flush) begin
      delay_cnt_d = '0;
      ii_cnt_d    = '0;
      clr         = 1'b1;
      done_d      = 1'b0;
      busy_d      = 1'b1;
      en_d        = NO_DELAY;
    end else if (!stall) begin
      case (state)
        WAIT: begin
          if (delay_cnt == DELAY_LAST) begin
            en_d     = 1'b1;
            ii_cnt_d = '0;
          end else begin
            delay_cnt_d = delay_cnt + WIDTH'(1);
          end
        end
        RUN: begin
          if (ii_wrap) begin
            ii_cnt_d = '0;
            if (last) begin
              done_d = 1'b1;
              busy_d = 1'b0;
            end else begin
              en_d  = 1'b1;
              issue = 1'b1;
            end
          end else begin
            ii_cnt_d = ii_cnt + WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      delay_cnt <= '0;
      ii_cnt    <= '0;
    end else begin
      en        <= en_d;
      busy      <= busy_d;
      done      <= done_d;
      delay_cnt <= delay_cnt_d;
      ii_cnt    <= ii_cnt_d;
    end
  end

`ifdef UB_AFFINE_CTRL_ADDR_EN
  // Address follows the indices' next value so it lands in the same cycle.
  logic [2:0][WIDTH-1:0] nxt;

  always_comb begin
    for (int d = 0; d < 3; d++) begin
      nxt[d] = ctrl_vars[d];
      if (clr)         nxt[d] = '0;
      else if (inc[d]) nxt[d] = wrap[d] ? '0 : ctrl_vars[d] + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr <= WIDTH'(OFFSET);
    else        addr <= WIDTH'(OFFSET) + WIDTH'(STRIDE0) * nxt[0]
                      + WIDTH'(STRIDE1) * nxt[1] + WIDTH'(STRIDE2) * nxt[2];
  end
`endif

endmodule

// File: tb/tb_ub_affine_ctrl.sv
// Directed bench for ub_affine_ctrl: default 1x62x62 domain, a 2x2x2 delayed/II=3 schedule, and 1x1x1.
module tb_ub_affine_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic flush_a, stall_a, en_a, busy_a, done_a;
  logic flush_b, stall_b, en_b, busy_b, done_b;
  logic flush_c, stall_c, en_c, busy_c, done_c;
  logic [2:0][15:0] cv_a, cv_b, cv_c;
`ifdef UB_AFFINE_CTRL_ADDR_EN
  logic [15:0] addr_a, addr_b, addr_c;
`endif

  int n_checks = 0;
  int n_errors = 0;

  int nev, nbad, ncyc, ev, bad, sbad, done_at, busy_bad;
  logic [47:0] cv62, cvlast;
  logic [15:0] addrlast;

  always #5 clk = ~clk;

  ub_affine_ctrl u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a), .stall(stall_a),
    .en(en_a), .ctrl_vars(cv_a), .busy(busy_a), .done(done_a)
`ifdef UB_AFFINE_CTRL_ADDR_EN
    , .addr(addr_a)
`endif
  );

  ub_affine_ctrl #(.EXT0(2), .EXT1(2), .EXT2(2), .START_DELAY(5), .II(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b), .stall(stall_b),
    .en(en_b), .ctrl_vars(cv_b), .busy(busy_b), .done(done_b)
`ifdef UB_AFFINE_CTRL_ADDR_EN
    , .addr(addr_b)
`endif
  );

  ub_affine_ctrl #(.EXT0(1), .EXT1(1), .EXT2(1), .START_DELAY(0), .II(2)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .flush(flush_c), .stall(stall_c),
    .en(en_c), .ctrl_vars(cv_c), .busy(busy_c), .done(done_c)
`ifdef UB_AFFINE_CTRL_ADDR_EN
    , .addr(addr_c)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Event e of the 1x62x62 nest: [0]=0, [1]=e/62, [2]=e%62.
  function automatic logic [47:0] exp_a(input int e);
    return {16'(e % 62), 16'(e / 62), 16'd0};
  endfunction

  function automatic logic [47:0] exp_b(input int k);
    return {16'(k & 1), 16'((k >> 1) & 1), 16'((k >> 2) & 1)};
  endfunction

  // Starts at a sample showing event 0; runs until done, counting events, gaps and order errors.
  task automatic run_to_done_a(output int n_ev, output int n_bad, output int n_cyc,
                               output logic [47:0] c62, output logic [47:0] clast,
                               output logic [15:0] alast);
    n_ev = 0; n_bad = 0; n_cyc = 0; c62 = '0; clast = '0; alast = '0;
    while (!done_a && n_cyc < 5000) begin
      if (en_a) begin
        if (cv_a !== exp_a(n_ev)) n_bad++;
        if (n_ev == 62) c62 = cv_a;
        clast = cv_a;
`ifdef UB_AFFINE_CTRL_ADDR_EN
        alast = addr_a;
`endif
        n_ev++;
      end else begin
        n_bad++;
      end
      step();
      n_cyc++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    flush_a = 0; stall_a = 0; flush_b = 0; stall_b = 0; flush_c = 0; stall_c = 0;
    repeat (3) step();
    chk("rst_en", 64'(en_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_cv", 64'(cv_a), 64'd0);
`ifdef UB_AFFINE_CTRL_ADDR_EN
    chk("rst_addr", 64'(addr_a), 64'd0);
`endif
    rst_n = 1'b1;
    step();
    chk("idle_no_en", 64'(en_a), 64'd0);

    // Full default schedule from a single flush pulse.
    flush_a = 1; step(); flush_a = 0;
    chk("a_first_en", 64'(en_a), 64'd1);
    chk("a_first_cv", 64'(cv_a), 64'd0);
    run_to_done_a(nev, nbad, ncyc, cv62, cvlast, addrlast);
    chk("a_events", 64'(nev), 64'd3844);
    chk("a_order", 64'(nbad), 64'd0);
    chk("a_done_cycle", 64'(ncyc), 64'd3844);
    chk("a_ev62_cv", 64'(cv62), {16'd0, 16'd0, 16'd1, 16'd0});
    chk("a_last_cv", 64'(cvlast), {16'd0, 16'd61, 16'd61, 16'd0});
`ifdef UB_AFFINE_CTRL_ADDR_EN
    chk("a_last_addr", 64'(addrlast), 64'd3843);
`endif
    chk("a_done_busy", 64'(busy_a), 64'd0);
    repeat (5) step();
    chk("a_done_sticky", 64'(done_a), 64'd1);

    // Stall 4 cycles after event 100, then flush at {0,10,7}.
    flush_a = 1; step(); flush_a = 0;
    ev = 0; bad = 0; sbad = 0;
    for (int c = 0; c < 2000 && ev <= 627; c++) begin
      if (en_a) begin
        if (cv_a !== exp_a(ev)) bad++;
        if (ev == 100) begin
          stall_a = 1;
          repeat (4) begin
            step();
            if (en_a !== 1'b0 || cv_a !== exp_a(100)) sbad++;
          end
          stall_a = 0;
        end
        ev++;
      end else begin
        bad++;
      end
      if (ev <= 627) step();
    end
    chk("s_reached", 64'(ev), 64'd628);
    chk("s_order", 64'(bad), 64'd0);
    chk("s_stall_hold", 64'(sbad), 64'd0);
    chk("s_at_flush_cv", 64'(cv_a), {16'd0, 16'd7, 16'd10, 16'd0});
    flush_a = 1; step(); flush_a = 0;
    chk("f_restart_en", 64'(en_a), 64'd1);
    chk("f_restart_cv", 64'(cv_a), 64'd0);
    run_to_done_a(nev, nbad, ncyc, cv62, cvlast, addrlast);
    chk("f_events", 64'(nev), 64'd3844);
    chk("f_order", 64'(nbad), 64'd0);
    chk("f_done_cycle", 64'(ncyc), 64'd3844);

    // Asynchronous reset in the middle of RUN.
    flush_a = 1; step(); flush_a = 0;
    repeat (50) step();
    chk("r_pre_en", 64'(en_a), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("r_en", 64'(en_a), 64'd0);
    chk("r_busy", 64'(busy_a), 64'd0);
    chk("r_cv", 64'(cv_a), 64'd0);
    rst_n = 1'b1;
    nev = 0;
    repeat (20) begin step(); if (en_a) nev++; end
    chk("r_no_events", 64'(nev), 64'd0);
    chk("r_idle_busy", 64'(busy_a), 64'd0);

    // 2x2x2, START_DELAY 5, II 3.
    flush_b = 1; step(); flush_b = 0;
    nev = 0; bad = 0; done_at = -1; busy_bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (en_b) begin
        if (c != 5 + 3 * nev || cv_b !== exp_b(nev)) bad++;
        nev++;
      end
      if (done_b && done_at < 0) done_at = c;
      if (c < 29 && busy_b !== 1'b1) busy_bad++;
      step();
    end
    chk("b_events", 64'(nev), 64'd8);
    chk("b_timing_order", 64'(bad), 64'd0);
    chk("b_done_at", 64'(done_at), 64'd29);
    chk("b_busy", 64'(busy_bad), 64'd0);
    chk("b_end_busy", 64'(busy_b), 64'd0);

    // 1x1x1, II 2.
    flush_c = 1; step(); flush_c = 0;
    nev = 0; bad = 0; done_at = -1;
    for (int c = 0; c < 10; c++) begin
      if (en_c) begin
        if (c != 0 || cv_c !== 48'd0) bad++;
        nev++;
      end
      if (done_c && done_at < 0) done_at = c;
      step();
    end
    chk("c_events", 64'(nev), 64'd1);
    chk("c_event_ok", 64'(bad), 64'd0);
    chk("c_done_at", 64'(done_at), 64'd2);
    chk("c_busy", 64'(busy_c), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
